// File: rtl/life_pkg.sv
// Shared types and the cell survival rule for the Game of Life board stepper.
package life_pkg;

  localparam int ROW_W = 8;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_COMMIT  = 2'd2
  } stepper_state_t;

  // Conway rule: birth on exactly 3 neighbours, survival on 2 or 3.
  function automatic logic cell_next(input logic alive, input logic [3:0] count);
    cell_next = (count == 4'd3) || (alive && (count == 4'd2));
  endfunction

endpackage

// File: rtl/life_board_stepper_if.sv
// Host-side bus of the board stepper: row loading, step control and committed-board readback.
interface life_board_stepper_if #(parameter int IDX_W = 3);
  import life_pkg::*;

  logic             load_valid;
  logic [IDX_W-1:0] load_idx;
  row_t             load_data;
  logic             step_start;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] rd_idx;
  row_t             rd_data;
  logic [15:0]      generation;

  modport master (
    output load_valid, load_idx, load_data, step_start, rd_idx,
    input  busy, done, rd_data, generation
  );

  modport slave (
    input  load_valid, load_idx, load_data, step_start, rd_idx,
    output busy, done, rd_data, generation
  );

endinterface

// File: rtl/life_board_stepper_cell_row.sv
// Evaluates one board row for the next generation from the row and its two vertical neighbours.
// Columns beyond either edge are treated as dead.
module cell_row
  import life_pkg::*;
(
  input  row_t top_row,
  input  row_t this_row,
  input  row_t bottom_row,
  output row_t next_state
);

  logic [ROW_W+1:0] top_pad_s;
  logic [ROW_W+1:0] mid_pad_s;
  logic [ROW_W+1:0] bot_pad_s;
  logic [3:0]       count_s [ROW_W];

  assign top_pad_s = {1'b0, top_row, 1'b0};
  assign mid_pad_s = {1'b0, this_row, 1'b0};
  assign bot_pad_s = {1'b0, bottom_row, 1'b0};

  // Padded index c+1 is column c; c and c+2 are its horizontal neighbours.
  for (genvar c = 0; c < ROW_W; c++) begin : g_col
    assign count_s[c] = 4'(top_pad_s[c]) + 4'(top_pad_s[c+1]) + 4'(top_pad_s[c+2])
                      + 4'(mid_pad_s[c])                      + 4'(mid_pad_s[c+2])
                      + 4'(bot_pad_s[c]) + 4'(bot_pad_s[c+1]) + 4'(bot_pad_s[c+2]);
    assign next_state[c] = cell_next(this_row[c], count_s[c]);
  end

endmodule

// File: rtl/life_board_stepper.sv
// Holds an 8x8 Life board and advances it one generation by streaming rows through cell_row,
// staging results in a shadow buffer that is committed in a single edge.
module life_board_stepper
  import life_pkg::*;
#(
  parameter int N_ROWS = 8
)(
  input  logic                 clk,
  input  logic                 rst,
  life_board_stepper_if.slave  bus
);

  localparam int IDX_W = $clog2(N_ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N_ROWS - 1);
  localparam logic [IDX_W-1:0] ONE_ROW  = IDX_W'(1);

  stepper_state_t          state_r;
  logic [IDX_W-1:0]        r_r;
  row_t [N_ROWS-1:0]       board_r;
  row_t [N_ROWS-1:0]       shadow_r;
  logic [15:0]             gen_r;
  logic                    busy_r;
  logic                    done_r;

  row_t top_s;
  row_t this_s;
  row_t bottom_s;
  row_t next_s;

  // Neighbour selection with a dead row above the first and below the last row.
  always_comb begin
    this_s = board_r[r_r];
    if (r_r == '0) begin
      top_s = 8'h00;
    end else begin
      top_s = board_r[r_r - ONE_ROW];
    end
    if (r_r == LAST_ROW) begin
      bottom_s = 8'h00;
    end else begin
      bottom_s = board_r[r_r + ONE_ROW];
    end
  end

  cell_row u_cell_row (
    .top_row    (top_s),
    .this_row   (this_s),
    .bottom_row (bottom_s),
    .next_state (next_s)
  );

  // Stepper FSM: loads only in IDLE, board stays frozen while shadow is filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      r_r      <= '0;
      board_r  <= '0;
      shadow_r <= '0;
      gen_r    <= 16'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.load_valid && (int'(bus.load_idx) < N_ROWS)) begin
            board_r[bus.load_idx] <= bus.load_data;
          end
          if (bus.step_start) begin
            state_r <= S_COMPUTE;
            r_r     <= '0;
            busy_r  <= 1'b1;
          end
        end
        S_COMPUTE: begin
          shadow_r[r_r] <= next_s;
          r_r           <= r_r + ONE_ROW;
          if (r_r == LAST_ROW) begin
            state_r <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          board_r <= shadow_r;
          gen_r   <= gen_r + 16'd1;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.generation = gen_r;
  assign bus.rd_data    = board_r[bus.rd_idx];

endmodule

// File: doc/life_board_stepper.md
# life_board_stepper

Sequential driver for the Game of Life row evaluator. Holds an 8x8 board and loads it row by row from a host. On request it advances the board by one generation by streaming each row, with its upper and lower neighbour rows, through a single `cell_row` instance, one row per cycle. Results are staged in a shadow buffer and committed atomically, so readers never see a half-updated board.

## Interface

Parameters:
- `N_ROWS`, 8: board height. Row width is fixed at 8 by `cell_row`. Row index width is `$clog2(N_ROWS)`.

Ports:
- `clk`, in, 1: sole clock; all state updates on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `load_valid`, in, 1: write `load_data` into board row `load_idx`. Honoured only in IDLE.
- `load_idx`, in, 3: row to load.
- `load_data`, in, 8: row contents; bit 0 is column 0.
- `step_start`, in, 1: request one generation. Sampled only in IDLE.
- `busy`, out, 1: high while COMPUTE or COMMIT.
- `done`, out, 1: one-cycle pulse; committed board and `generation` are already updated.
- `rd_idx`, in, 3: committed-board read address.
- `rd_data`, out, 8: combinational read of committed row `rd_idx`.
- `generation`, out, 16: count of committed generations. Wraps 16'hFFFF to 0.

## Operation

- States: IDLE, COMPUTE, COMMIT.
  - IDLE → COMPUTE on `step_start`.
  - COMPUTE → COMMIT when row counter `r` == N_ROWS-1.
  - COMMIT → IDLE unconditionally.
- On IDLE→COMPUTE: `r` is cleared to 0.
- Row feed in COMPUTE:
  - `this_row` = board[r].
  - `top_row` = board[r-1], or 8'h00 when r==0.
  - `bottom_row` = board[r+1], or 8'h00 when r==N_ROWS-1.
  - The board boundary is dead. There is no wrap-around in either axis.
- Each COMPUTE cycle writes `cell_row.next_state` into shadow[r], then increments `r`.
- The committed board is read-only during COMPUTE. Every row therefore sees generation-n neighbours.
- COMMIT:
  - board ← shadow, all rows in one edge.
  - `generation` ← `generation`+1.
  - `done` is set for the following cycle.
- Load in IDLE: board[load_idx] ← load_data at the edge. `load_idx` ≥ N_ROWS is ignored.
- `load_valid` in COMPUTE/COMMIT: dropped silently.
- `step_start` while busy: ignored. It is not queued.
- `load_valid` and `step_start` together in IDLE: both are accepted. The loaded row is in place before row 0 is evaluated, so the step uses it.
- Reset (any state, including mid-COMPUTE):
  - Board, shadow, `r` and `generation` go to 0.
  - State goes to IDLE.
  - `busy`=0 and `done`=0.
  - A partially computed generation is discarded; no `done` is issued.

## Timing

- Cycle 0: `step_start` sampled high in IDLE.
- Cycles 1..N_ROWS: COMPUTE, rows 0..N_ROWS-1. `busy`=1.
- Cycle N_ROWS+1: COMMIT. `busy`=1. The board updates at the end of this cycle.
- Cycle N_ROWS+2: IDLE, `done`=1, `busy`=0. `rd_data` shows the new generation. A new `step_start` may be sampled in this same cycle.
- Start-to-done latency is N_ROWS+2 cycles (10 for default). Back-to-back throughput is one generation per N_ROWS+2 cycles.
- `busy` and `done` are registered. `rd_data` is combinational from `rd_idx` and the committed board.
- Reset values: `busy`=0, `done`=0, `generation`=0, `rd_data`=8'h00 for any `rd_idx`.

## Structure

- Shared package `life_pkg` holds:
  - `ROW_W` = 8.
  - `typedef logic [ROW_W-1:0] row_t`.
  - `typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_COMMIT} stepper_state_t`.
- Board and shadow are `row_t [N_ROWS-1:0]` arrays.
- One sub-module instance: `cell_row`, used unchanged as the per-row evaluator. Neighbour muxing and zero-padding live in this block.

## Test plan

- Reset: assert `rst` for 2 cycles.
  - Required: `busy`=0, `done`=0, `generation`=0, `rd_data`=8'h00 for all `rd_idx`.
- Blinker:
  - Load row 3 = 8'b0001_1100, then step. Required: rows 2, 3, 4 = 8'b0000_1000, all other rows 0, `generation`=1, `done` exactly at cycle 10.
  - Step again. Required: row 3 = 8'b0001_1100, other rows 0, `generation`=2.
- Corner block: rows 0 and 1 = 8'b0000_0011, then step.
  - Required: board unchanged, which checks zero padding at the top edge and at column 0.
- Busy protection: start a step, then pulse `load_valid` (row 5 = 8'hFF) and `step_start` at cycle 4.
  - Required: row 5 unchanged by the load, a single `done`, `generation` +1.
- Mid-operation reset: load the blinker, start a step, assert `rst` at cycle 4.
  - Required: all rows 0, `busy`=0, no `done`, `generation`=0.
- Simultaneous load and start: load row 3 = 8'b0001_1100 with `step_start` in the same cycle.
  - Required: the vertical blinker result (rows 2, 3, 4 = 8'b0000_1000) at cycle 10.
